exec_redirect_unit: RTL and testbench

- Execute-stage control-flow resolver for the 5-stage pipeline.
- Takes decoded branch/JAL operands from decode and evaluates the branch condition.
- Produces the registered redirect that drives the fetch stage's PC mux, plus the link-register writeback value.
- Runs a squash state machine that kills the wrong-path instructions already fetched behind a taken redirect.

---
 rtl/exec_redirect_unit_pkg.sv | 32 +++
 rtl/exec_redirect_unit_if.sv | 29 ++
 rtl/exec_redirect_unit_branch_cond_eval.sv | 32 +++
 rtl/exec_redirect_unit.sv | 112 +++++++++++
 tb/tb_exec_redirect_unit.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/exec_redirect_unit_pkg.sv
// Shared control-flow definitions for decode and execute: instruction kinds,
// branch condition codes and the sequential PC step.
package exec_redirect_unit_pkg;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_JAL    = 2'd2,
    KIND_RSVD   = 2'd3
  } kind_e;

  // Encoding matches the decoder; codes 8..15 are undefined and never taken.
  typedef enum logic [3:0] {
    COND_F   = 4'd0,
    COND_EQ  = 4'd1,
    COND_LT  = 4'd2,
    COND_LTE = 4'd3,
    COND_T   = 4'd4,
    COND_NE  = 4'd5,
    COND_GTE = 4'd6,
    COND_GT  = 4'd7
  } cond_e;

  localparam int INSTR_BYTES = 4;
  localparam int SQ_CNT_W    = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SQUASH = 1'b1
  } redir_state_e;

endpackage

// File: rtl/exec_redirect_unit_if.sv
// Decode-to-execute control-flow bundle plus the redirect/link/stats results.
interface exec_redirect_unit_if #(parameter int DBITS = 32);
  logic             in_valid;
  logic [1:0]       in_kind;
  logic [3:0]       in_cond;
  logic [DBITS-1:0] in_pc;
  logic [DBITS-1:0] in_rs1;
  logic [DBITS-1:0] in_rs2;
  logic [DBITS-1:0] in_imm;
  logic             redirect_valid;
  logic [DBITS-1:0] redirect_pc;
  logic             link_we;
  logic [DBITS-1:0] link_value;
  logic             squash;
  logic [31:0]      branch_count;
  logic [31:0]      taken_count;

  modport master (
    output in_valid, in_kind, in_cond, in_pc, in_rs1, in_rs2, in_imm,
    input  redirect_valid, redirect_pc, link_we, link_value, squash,
           branch_count, taken_count
  );

  modport slave (
    input  in_valid, in_kind, in_cond, in_pc, in_rs1, in_rs2, in_imm,
    output redirect_valid, redirect_pc, link_we, link_value, squash,
           branch_count, taken_count
  );
endinterface

// File: rtl/exec_redirect_unit_branch_cond_eval.sv
// Combinational signed branch-condition evaluator; also used by the decoder's
// static-prediction hook.
module branch_cond_eval
  import exec_redirect_unit_pkg::*;
#(
  parameter int DBITS = 32
) (
  input  logic [3:0]       cond,
  input  logic [DBITS-1:0] rs1,
  input  logic [DBITS-1:0] rs2,
  output logic             taken
);
  logic eq, lt;

  assign eq = (rs1 == rs2);
  assign lt = ($signed(rs1) < $signed(rs2));

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_F:   taken = 1'b0;
      COND_EQ:  taken = eq;
      COND_LT:  taken = lt;
      COND_LTE: taken = lt | eq;
      COND_T:   taken = 1'b1;
      COND_NE:  taken = ~eq;
      COND_GTE: taken = ~lt;
      COND_GT:  taken = ~(lt | eq);
      default:  taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/exec_redirect_unit.sv
// Execute-stage redirect resolver: registered fetch redirect, JAL link write and
// wrong-path squash FSM. Define BRANCH_STATS_EN to build the branch/taken counters.
module exec_redirect_unit
  import exec_redirect_unit_pkg::*;
#(
  parameter int DBITS        = 32,
  parameter int START_PC     = 64,
  parameter int SQUASH_SLOTS = 2
) (
  input logic               clk,
  input logic               reset,
  exec_redirect_unit_if.slave bus
);
  redir_state_e        state;
  logic [SQ_CNT_W-1:0] sqCnt;
  logic                redirectValid, linkWe, squash;
  logic [DBITS-1:0]    redirectPc, linkValue;

  logic             condTaken, isBranch, isJal, accept, brTaken, jalGo, redirect;
  logic [DBITS-1:0] seqPc, immOff, brTarget, jalTarget;

  branch_cond_eval #(.DBITS(DBITS)) uCond (
    .cond  (bus.in_cond),
    .rs1   (bus.in_rs1),
    .rs2   (bus.in_rs2),
    .taken (condTaken)
  );

  assign isBranch  = (bus.in_kind == KIND_BRANCH);
  assign isJal     = (bus.in_kind == KIND_JAL);
  assign accept    = bus.in_valid && (state == ST_IDLE);
  assign brTaken   = accept && isBranch && condTaken;
  assign jalGo     = accept && isJal;
  assign redirect  = brTaken || jalGo;

  // Immediate is in words; all target math wraps at 2^DBITS.
  assign seqPc     = bus.in_pc + DBITS'(INSTR_BYTES);
  assign immOff    = bus.in_imm << 2;
  assign brTarget  = seqPc + immOff;
  assign jalTarget = bus.in_rs1 + immOff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      sqCnt         <= '0;
      redirectValid <= 1'b0;
      redirectPc    <= DBITS'(START_PC);
      linkWe        <= 1'b0;
      linkValue     <= '0;
      squash        <= 1'b0;
    end else begin
      redirectValid <= 1'b0;
      linkWe        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (redirect) begin
            redirectValid <= 1'b1;
            redirectPc    <= jalGo ? jalTarget : brTarget;
            state         <= ST_SQUASH;
            sqCnt         <= SQ_CNT_W'(SQUASH_SLOTS);
            squash        <= 1'b1;
          end
          if (jalGo) begin
            linkWe    <= 1'b1;
            linkValue <= seqPc;
          end
        end
        ST_SQUASH: begin
          // Leaving on count 1 keeps squash high for exactly SQUASH_SLOTS cycles.
          if (sqCnt == SQ_CNT_W'(1)) begin
            state  <= ST_IDLE;
            sqCnt  <= '0;
            squash <= 1'b0;
          end else begin
            sqCnt <= sqCnt - SQ_CNT_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          sqCnt  <= '0;
          squash <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] branchCount, takenCount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branchCount <= '0;
      takenCount  <= '0;
    end else begin
      if (accept && isBranch) branchCount <= branchCount + 32'd1;
      if (redirect)           takenCount  <= takenCount + 32'd1;
    end
  end

  assign bus.branch_count = branchCount;
  assign bus.taken_count  = takenCount;
`else
  assign bus.branch_count = '0;
  assign bus.taken_count  = '0;
`endif

  assign bus.redirect_valid = redirectValid;
  assign bus.redirect_pc    = redirectPc;
  assign bus.link_we        = linkWe;
  assign bus.link_value     = linkValue;
  assign bus.squash         = squash;
endmodule

// File: tb/tb_exec_redirect_unit.sv
// Scoreboard bench for exec_redirect_unit: directed spec cases plus random
// stimulus checked against a cycle-level behavioural model.
module tb_exec_redirect_unit;
  localparam int SLOTS = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exec_redirect_unit_if #(.DBITS(32)) bus ();

  exec_redirect_unit #(.DBITS(32), .START_PC(64), .SQUASH_SLOTS(SLOTS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          rv;
    logic [31:0] rpc;
    bit          lwe;
    logic [31:0] lval;
    bit          sq;
    logic [31:0] bc;
    logic [31:0] tc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Model state: remaining dropped sample edges, last target/link, stats.
  int          killLeft;
  logic [31:0] mPc, mLval, mBc, mTc;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit modelTaken(int c, int a, int b);
    case (c)
      1: return a == b;
      2: return a < b;
      3: return a <= b;
      4: return 1'b1;
      5: return a != b;
      6: return a >= b;
      7: return a > b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] statExp(logic [31:0] v);
`ifdef BRANCH_STATS_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic modelReset();
    killLeft = 0;
    mPc = 32'h40; mLval = 0; mBc = 0; mTc = 0;
  endtask

  task automatic step(bit v, int k, int c, logic [31:0] pc, logic [31:0] rs1,
                      logic [31:0] rs2, logic [31:0] imm);
    exp_t e;
    @(negedge clk);
    bus.in_valid = v; bus.in_kind = 2'(k); bus.in_cond = 4'(c);
    bus.in_pc = pc; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
    e.rv = 0; e.lwe = 0;
    if (killLeft > 0) killLeft--;
    else if (v) begin
      if (k == 1) begin
        mBc++;
        if (modelTaken(c, int'(rs1), int'(rs2))) begin
          mPc = pc + 4 + imm * 4; e.rv = 1; killLeft = SLOTS; mTc++;
        end
      end else if (k == 2) begin
        mPc = rs1 + imm * 4; mLval = pc + 4; e.rv = 1; e.lwe = 1;
        killLeft = SLOTS; mTc++;
      end
    end
    e.rpc = mPc; e.lval = mLval; e.sq = (killLeft > 0);
    e.bc = statExp(mBc); e.tc = statExp(mTc);
    sbq.push_back(e);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one expected record per sampled cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("redirect_valid", 32'(bus.redirect_valid), 32'(e.rv));
        chk("redirect_pc", bus.redirect_pc, e.rpc);
        chk("link_we", 32'(bus.link_we), 32'(e.lwe));
        chk("link_value", bus.link_value, e.lval);
        chk("squash", 32'(bus.squash), 32'(e.sq));
        chk("branch_count", bus.branch_count, e.bc);
        chk("taken_count", bus.taken_count, e.tc);
      end
    end
  end

  task automatic drain();
    int budget = 50;
    while (sbq.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] vals [5];
    vals[0] = 32'd0; vals[1] = 32'd1; vals[2] = 32'hFFFFFFFF;
    vals[3] = 32'h7FFFFFFF; vals[4] = 32'h80000000;
    reset = 1'b1;
    bus.in_valid = 0; bus.in_kind = 0; bus.in_cond = 0;
    bus.in_pc = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_imm = 0;
    modelReset();
    #12;
    chk("rst_redirect_pc", bus.redirect_pc, 32'h40);
    chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("rst_squash", 32'(bus.squash), 32'd0);
    chk("rst_link_value", bus.link_value, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // BEQ taken then JAL, three loops with valid instructions during squash.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 32'h0, 5, 5, 32'hF);
      step(1, 1, 4, 32'h40, 0, 0, 0);
      step(1, 2, 0, 32'h44, 0, 0, 0);
      step(1, 2, 0, 32'h44, 0, 0, 0);
      step(1, 1, 4, 32'h0, 0, 0, 0);
      step(1, 1, 4, 32'h0, 0, 0, 0);
    end
    // Not-taken signed BLT, next instruction accepted immediately.
    step(1, 1, 2, 32'h100, 3, 32'hFFFFFFFF, 4);
    step(1, 1, 4, 32'h200, 0, 0, 0);
    idle(2);
    // Wrap-around targets.
    step(1, 1, 4, 32'hFFFFFFFC, 0, 0, 1);
    idle(2);
    step(1, 2, 0, 32'h80, 32'h10, 0, 32'hFFFFFFFC);
    idle(2);
    // NONE, reserved kind and undefined cond have no effect.
    step(1, 0, 4, 32'h300, 0, 0, 8);
    step(1, 3, 4, 32'h300, 0, 0, 8);
    step(1, 1, 9, 32'h300, 7, 7, 8);
    step(1, 1, 0, 32'h300, 7, 7, 8);
    drain();

    // Reset asserted mid-squash acts without a clock edge.
    step(1, 1, 4, 32'h500, 0, 0, 4);
    @(negedge clk);
    bus.in_valid = 0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_squash", 32'(bus.squash), 32'd0);
    chk("midrst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("midrst_redirect_pc", bus.redirect_pc, 32'h40);
    chk("midrst_branch_count", bus.branch_count, 32'd0);
    modelReset();
    @(negedge clk);
    reset = 1'b0;

    // Stats: 5 branches (3 taken) + 2 JALs, one branch dropped in squash.
    step(1, 1, 4, 32'h0, 0, 0, 1);
    step(1, 1, 4, 32'h0, 0, 0, 1);
    idle(1);
    step(1, 1, 0, 32'h0, 0, 0, 1);
    step(1, 1, 1, 32'h0, 2, 2, 1);
    idle(2);
    step(1, 1, 7, 32'h0, 1, 2, 1);
    step(1, 2, 0, 32'h20, 32'h100, 0, 0);
    idle(2);
    step(1, 1, 6, 32'h0, 2, 2, 3);
    idle(2);
    step(1, 2, 0, 32'h30, 32'h200, 0, 0);
    idle(3);
    drain();
`ifdef BRANCH_STATS_EN
    chk("stats_branch_count", bus.branch_count, 32'd5);
    chk("stats_taken_count", bus.taken_count, 32'd5);
`else
    chk("stats_branch_count", bus.branch_count, 32'd0);
    chk("stats_taken_count", bus.taken_count, 32'd0);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 9)),
           {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
           vals[$urandom_range(0, 4)], vals[$urandom_range(0, 4)], $urandom);
    end
    idle(3);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
